issue_scheduler: RTL and testbench
==================================

Name: issue_scheduler

Overview:
- Selects, each cycle, the oldest ready reservation-station entry for each of the three functional units: FU0 ALU, FU1 ALU, FU2 memory.
- Tracks per-FU occupancy so a multi-cycle unit is never double-issued.
- Sits between the reservation-station array and the FU issue ports in the dispatch/issue stage.
- Replaces ad-hoc first-free scanning with oldest-first selection that is aware of ROB wrap-around.

Parameters:
- NUM_ENTRIES, 16, number of reservation-station entries scanned.
- ROB_W, 4, ROB-number width; ages are compared modulo 2^ROB_W.
- ALU_LAT, 1, issue interval in cycles for FU0 and FU1 (range 1..15).
- MEM_LAT, 2, issue interval in cycles for FU2 (range 1..15).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_flush  in  1  synchronous pipeline flush; cancels pending grants and occupancy.
- i_ready  in  NUM_ENTRIES  entry e is in use with both sources ready.
- i_fu_sel  in  2*NUM_ENTRIES  target FU of entry e in bits [2e+1:2e]; value 3 means no FU, never granted.
- i_age  in  ROB_W*NUM_ENTRIES  ROB number of entry e.
- i_rob_head  in  ROB_W  ROB number of the oldest in-flight instruction.
- i_fu_stall  in  3  FU f cannot accept work this cycle.
- o_grant_valid  out  3  a grant to FU f was registered this cycle.
- o_grant_idx  out  12  granted entry index for FU f in bits [4f+3:4f].
- o_clear  out  NUM_ENTRIES  one-hot-per-FU mask of granted entries; the reservation station frees them.
- o_fu_busy  out  3  FU f occupancy counter is nonzero.

Behaviour:
- Reset (i_rst=1 at an edge): all outputs 0, all occupancy counters 0, last-grant mask 0. Reset has priority over flush and every other input.
- Eligibility of entry e for FU f, all of the following:
  - i_ready[e]=1;
  - i_fu_sel[e]==f;
  - e is not set in the registered o_clear. The RS frees entries one cycle late, so an entry just granted is never granted twice.
- Relative age of entry e = (i_age[e] - i_rob_head) mod 2^ROB_W, ROB_W bits, unsigned. The smallest relative age wins; ties go to the lowest index.
- FU f may be granted when all of the following hold:
  - its counter is 0;
  - i_fu_stall[f]=0;
  - i_flush=0;
  - at least one entry is eligible for it.
- Grant at edge k, registered, visible in the cycle after edge k:
  - o_grant_valid[f]=1;
  - o_grant_idx[f] = winner index;
  - o_clear has the winner's bit set;
  - counter[f] = LAT-1, where LAT is ALU_LAT for FU0/FU1 and MEM_LAT for FU2.
- No grant: o_grant_valid[f]=0 and o_grant_idx[f]=0; that FU contributes no o_clear bit.
- Outputs are pulses; each grant lasts exactly one cycle.
- Counter per FU:
  - decrements by 1 per edge while nonzero and i_fu_stall[f]=0;
  - holds while stalled.
- o_fu_busy[f] = (counter[f]!=0), registered with the counter.
- Issue rates:
  - LAT=1: back-to-back grants every cycle.
  - MEM_LAT=2: at most one grant every 2 cycles.
- Stall: blocks new grants to FU f and freezes its counter. An already-registered grant pulse is not retracted.
- Flush at edge k: counters, o_grant_valid, o_clear and the last-grant mask are all 0 after edge k. A flush coincident with eligible entries produces no grant.
- The three FUs arbitrate independently. An entry targets exactly one FU, so o_clear never has conflicting bits.
- Multiple grants in one cycle: o_clear may have up to 3 bits set.
- Wrap-around:
  - i_rob_head=14: ages 14, 15, 0, 1 rank oldest to youngest.
  - Age equal to the head is the oldest.
- Latency: request to grant is 1 cycle. Combinational selection depth is a log2(NUM_ENTRIES) compare tree per FU.

Test Plan:
- Reset: assert i_rst for 2 cycles with all i_ready=1. Required: o_grant_valid=0, o_clear=0 and o_fu_busy=0 throughout reset and the cycle after deassertion.
- Oldest-first: entries 3, 7 and 9 target FU0 with ages 5, 2, 2 and i_rob_head=0. Required: grant idx 7. Next cycle (7 masked, i_ready[7] still 1): grant idx 9. Then grant idx 3.
- Wrap-around: i_rob_head=14; entry 1 age 0, entry 2 age 15, both FU1. Required: entry 2 granted first, entry 1 on the next cycle.
- Memory occupancy, MEM_LAT=2: entries 4 and 5 target FU2, ready continuously.
  - Grant 4 at cycle t+1 with o_fu_busy[2]=1.
  - No grant at t+2; o_fu_busy[2]=0.
  - Grant 5 at t+3.
- Stall: FU2 busy (counter 1) with i_fu_stall[2]=1 held 3 cycles. Required: o_fu_busy[2] stays 1 and no grant. After release: busy drops next cycle, and the pending entry is granted the cycle after.
- Flush versus parallel grants:
  - Entries 0/1/2 target FU0/FU1/FU2; in the same cycle, assert i_flush. Required: no grants.
  - Next cycle (flush low): three simultaneous grants, o_clear=0x0007, o_grant_idx=0x210.

Source files
------------

// File: rtl/issue_scheduler.sv
// Oldest-first issue selection for two ALU ports and one memory port.
// Each FU has its own age-compare tree and an occupancy down-counter.
module issue_scheduler #(
   parameter int NUM_ENTRIES = 16,
   parameter int ROB_W       = 4,
   parameter int ALU_LAT     = 1,
   parameter int MEM_LAT     = 2,
   localparam int IDX_W      = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_flush,
   input  logic [NUM_ENTRIES-1:0]       i_ready,
   input  logic [2*NUM_ENTRIES-1:0]     i_fu_sel,
   input  logic [ROB_W*NUM_ENTRIES-1:0] i_age,
   input  logic [ROB_W-1:0]             i_rob_head,
   input  logic [2:0]                   i_fu_stall,
   output logic [2:0]                   o_grant_valid,
   output logic [3*IDX_W-1:0]           o_grant_idx,
   output logic [NUM_ENTRIES-1:0]       o_clear,
   output logic [2:0]                   o_fu_busy
);

   localparam int P     = 1 << IDX_W;
   localparam int CNT_W = 4;
   localparam logic [CNT_W-1:0] ALU_RELOAD = CNT_W'(ALU_LAT - 1);
   localparam logic [CNT_W-1:0] MEM_RELOAD = CNT_W'(MEM_LAT - 1);

   logic [2:0][CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]              valid_q, valid_d;
   logic [3*IDX_W-1:0]      idx_q, idx_d;
   logic [NUM_ENTRIES-1:0]  clear_q, clear_d;
   logic [2:0]              busy_q, busy_d;

   logic [ROB_W-1:0]        rel_age [NUM_ENTRIES];
   logic [2:0]              win_vld;
   logic [2:0][IDX_W-1:0]   win_idx;
   logic [2:0]              grant;

   // Ages are taken relative to the ROB head so wrap-around ranks correctly.
   always_comb begin
      for (int e = 0; e < NUM_ENTRIES; e++) begin
         rel_age[e] = i_age[e*ROB_W +: ROB_W] - i_rob_head;
      end
   end

   // Heap-ordered compare tree per FU; the left child wins ties so the lower index is kept.
   always_comb begin : p_select
      logic [2*P-1:0]            v;
      logic [2*P-1:0][ROB_W-1:0] a;
      logic [2*P-1:0][IDX_W-1:0] x;
      win_vld = '0;
      win_idx = '0;
      for (int f = 0; f < 3; f++) begin
         v = '0;
         a = '0;
         x = '0;
         for (int e = 0; e < NUM_ENTRIES; e++) begin
            v[P+e] = i_ready[e] && (i_fu_sel[2*e +: 2] == 2'(f)) && !clear_q[e];
            a[P+e] = rel_age[e];
            x[P+e] = IDX_W'(e);
         end
         for (int n = P-1; n >= 1; n--) begin
            if (v[2*n] && (!v[2*n+1] || (a[2*n] <= a[2*n+1]))) begin
               a[n] = a[2*n];
               x[n] = x[2*n];
            end else begin
               a[n] = a[2*n+1];
               x[n] = x[2*n+1];
            end
            v[n] = v[2*n] | v[2*n+1];
         end
         win_vld[f] = v[1];
         win_idx[f] = x[1];
      end
   end

   always_comb begin
      grant   = '0;
      cnt_d   = cnt_q;
      valid_d = '0;
      idx_d   = '0;
      clear_d = '0;
      busy_d  = '0;
      for (int f = 0; f < 3; f++) begin
         grant[f] = win_vld[f] && (cnt_q[f] == '0) && !i_fu_stall[f] && !i_flush;
         if (i_flush) begin
            cnt_d[f] = '0;
         end else if (grant[f]) begin
            cnt_d[f] = (f == 2) ? MEM_RELOAD : ALU_RELOAD;
         end else if ((cnt_q[f] != '0) && !i_fu_stall[f]) begin
            cnt_d[f] = cnt_q[f] - 1'b1;
         end
         if (grant[f]) begin
            valid_d[f]                = 1'b1;
            idx_d[f*IDX_W +: IDX_W]   = win_idx[f];
            clear_d[win_idx[f]]       = 1'b1;
         end
         busy_d[f] = (cnt_d[f] != '0);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q   <= '0;
         valid_q <= '0;
         idx_q   <= '0;
         clear_q <= '0;
         busy_q  <= '0;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         idx_q   <= idx_d;
         clear_q <= clear_d;
         busy_q  <= busy_d;
      end
   end

   assign o_grant_valid = valid_q;
   assign o_grant_idx   = idx_q;
   assign o_clear       = clear_q;
   assign o_fu_busy     = busy_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Directed scenarios plus randomized traffic against a queue-free reference model
// that ranks entries by (age - head) mod 16 and tracks FU occupancy as integers.
module tb_issue_scheduler;

   localparam int ALU_LAT = 1;
   localparam int MEM_LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic [15:0] ready = '0;
   logic [31:0] fu_sel = '1;
   logic [63:0] age = '0;
   logic [3:0]  head = '0;
   logic [2:0]  stall = '0;
   logic [2:0]  grant_valid;
   logic [11:0] grant_idx;
   logic [15:0] clear;
   logic [2:0]  fu_busy;

   int checks = 0;
   int errors = 0;

   int          m_cnt [3];
   logic [2:0]  exp_valid = '0;
   logic [11:0] exp_idx = '0;
   logic [15:0] exp_clear = '0;
   logic [2:0]  exp_busy = '0;

   issue_scheduler #(.NUM_ENTRIES(16), .ROB_W(4), .ALU_LAT(ALU_LAT), .MEM_LAT(MEM_LAT)) dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_ready(ready), .i_fu_sel(fu_sel),
      .i_age(age), .i_rob_head(head), .i_fu_stall(stall),
      .o_grant_valid(grant_valid), .o_grant_idx(grant_idx), .o_clear(clear), .o_fu_busy(fu_busy)
   );

   always #5 clk = ~clk;

   task automatic model_step();
      logic [2:0]  nv;
      logic [11:0] ni;
      logic [15:0] nc;
      int best, bage, rel;
      nv = '0; ni = '0; nc = '0;
      if (rst) begin
         for (int f = 0; f < 3; f++) m_cnt[f] = 0;
      end else begin
         for (int f = 0; f < 3; f++) begin
            best = -1;
            bage = 99;
            if (!flush && m_cnt[f] == 0 && !stall[f]) begin
               for (int e = 0; e < 16; e++) begin
                  if (ready[e] && fu_sel[2*e +: 2] == 2'(f) && !exp_clear[e]) begin
                     rel = (int'(age[4*e +: 4]) - int'(head) + 16) % 16;
                     if (rel < bage) begin
                        bage = rel;
                        best = e;
                     end
                  end
               end
            end
            if (flush) m_cnt[f] = 0;
            else if (best >= 0) m_cnt[f] = ((f == 2) ? MEM_LAT : ALU_LAT) - 1;
            else if (m_cnt[f] != 0 && !stall[f]) m_cnt[f] = m_cnt[f] - 1;
            if (best >= 0) begin
               nv[f] = 1'b1;
               ni[4*f +: 4] = 4'(best);
               nc[best] = 1'b1;
            end
         end
      end
      exp_valid = nv;
      exp_idx   = ni;
      exp_clear = nc;
      for (int f = 0; f < 3; f++) exp_busy[f] = (m_cnt[f] != 0);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_entry(input int e, input int fu, input int a, input logic r);
      fu_sel[2*e +: 2] = 2'(fu);
      age[4*e +: 4]    = 4'(a);
      ready[e]         = r;
   endtask

   task automatic quiesce();
      ready = '0; fu_sel = '1; stall = '0; flush = 1'b0; head = '0; age = '0;
      tick();
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ready = '1;
      for (int e = 0; e < 16; e++) fu_sel[2*e +: 2] = 2'(e % 3);
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++;
         if (grant_valid !== 3'b000) begin errors++; $display("FAIL reset_valid got %b exp 000", grant_valid); end
         checks++;
         if (clear !== 16'h0) begin errors++; $display("FAIL reset_clear got %h exp 0000", clear); end
         checks++;
         if (fu_busy !== 3'b000) begin errors++; $display("FAIL reset_busy got %b exp 000", fu_busy); end
      end
      rst = 1'b0;
      #1;
      checks++;
      if (grant_valid !== 3'b000 || clear !== 16'h0 || fu_busy !== 3'b000) begin
         errors++;
         $display("FAIL reset_release got v=%b c=%h b=%b exp all zero", grant_valid, clear, fu_busy);
      end
      quiesce();
   endtask

   task automatic test_oldest_first();
      set_entry(3, 0, 5, 1'b1);
      set_entry(7, 0, 2, 1'b1);
      set_entry(9, 0, 2, 1'b1);
      tick();
      checks++;
      if (grant_valid[0] !== 1'b1 || grant_idx[3:0] !== 4'd7 || clear !== 16'h0080) begin
         errors++;
         $display("FAIL oldest_first_1 got v=%b idx=%0d clr=%h exp v=1 idx=7 clr=0080", grant_valid[0], grant_idx[3:0], clear);
      end
      tick();
      checks++;
      if (grant_valid[0] !== 1'b1 || grant_idx[3:0] !== 4'd9) begin
         errors++;
         $display("FAIL oldest_first_2 got v=%b idx=%0d exp v=1 idx=9", grant_valid[0], grant_idx[3:0]);
      end
      ready[7] = 1'b0;
      tick();
      checks++;
      if (grant_valid[0] !== 1'b1 || grant_idx[3:0] !== 4'd3) begin
         errors++;
         $display("FAIL oldest_first_3 got v=%b idx=%0d exp v=1 idx=3", grant_valid[0], grant_idx[3:0]);
      end
      quiesce();
   endtask

   task automatic test_wrap();
      head = 4'd14;
      set_entry(1, 1, 0, 1'b1);
      set_entry(2, 1, 15, 1'b1);
      set_entry(0, 0, 15, 1'b1);
      set_entry(3, 0, 14, 1'b1);
      tick();
      checks++;
      if (grant_valid[1] !== 1'b1 || grant_idx[7:4] !== 4'd2) begin
         errors++;
         $display("FAIL wrap_first got v=%b idx=%0d exp v=1 idx=2", grant_valid[1], grant_idx[7:4]);
      end
      checks++;
      if (grant_valid[0] !== 1'b1 || grant_idx[3:0] !== 4'd3) begin
         errors++;
         $display("FAIL wrap_head_oldest got v=%b idx=%0d exp v=1 idx=3", grant_valid[0], grant_idx[3:0]);
      end
      tick();
      checks++;
      if (grant_valid[1] !== 1'b1 || grant_idx[7:4] !== 4'd1) begin
         errors++;
         $display("FAIL wrap_second got v=%b idx=%0d exp v=1 idx=1", grant_valid[1], grant_idx[7:4]);
      end
      quiesce();
   endtask

   task automatic test_mem_occupancy();
      set_entry(4, 2, 0, 1'b1);
      set_entry(5, 2, 1, 1'b1);
      tick();
      checks++;
      if (grant_valid[2] !== 1'b1 || grant_idx[11:8] !== 4'd4 || fu_busy[2] !== 1'b1) begin
         errors++;
         $display("FAIL mem_grant4 got v=%b idx=%0d busy=%b exp v=1 idx=4 busy=1", grant_valid[2], grant_idx[11:8], fu_busy[2]);
      end
      ready[4] = 1'b0;
      tick();
      checks++;
      if (grant_valid[2] !== 1'b0 || fu_busy[2] !== 1'b0) begin
         errors++;
         $display("FAIL mem_gap got v=%b busy=%b exp v=0 busy=0", grant_valid[2], fu_busy[2]);
      end
      tick();
      checks++;
      if (grant_valid[2] !== 1'b1 || grant_idx[11:8] !== 4'd5) begin
         errors++;
         $display("FAIL mem_grant5 got v=%b idx=%0d exp v=1 idx=5", grant_valid[2], grant_idx[11:8]);
      end
      quiesce();
   endtask

   task automatic test_stall();
      set_entry(4, 2, 0, 1'b1);
      set_entry(5, 2, 1, 1'b1);
      tick();
      ready[4] = 1'b0;
      stall[2] = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if (fu_busy[2] !== 1'b1 || grant_valid[2] !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold got busy=%b v=%b exp busy=1 v=0", fu_busy[2], grant_valid[2]);
         end
      end
      stall[2] = 1'b0;
      tick();
      checks++;
      if (fu_busy[2] !== 1'b0 || grant_valid[2] !== 1'b0) begin
         errors++;
         $display("FAIL stall_release got busy=%b v=%b exp busy=0 v=0", fu_busy[2], grant_valid[2]);
      end
      tick();
      checks++;
      if (grant_valid[2] !== 1'b1 || grant_idx[11:8] !== 4'd5) begin
         errors++;
         $display("FAIL stall_pending got v=%b idx=%0d exp v=1 idx=5", grant_valid[2], grant_idx[11:8]);
      end
      quiesce();
   endtask

   task automatic test_flush_parallel();
      set_entry(0, 0, 3, 1'b1);
      set_entry(1, 1, 4, 1'b1);
      set_entry(2, 2, 5, 1'b1);
      flush = 1'b1;
      tick();
      checks++;
      if (grant_valid !== 3'b000 || clear !== 16'h0) begin
         errors++;
         $display("FAIL flush_block got v=%b clr=%h exp v=000 clr=0000", grant_valid, clear);
      end
      flush = 1'b0;
      tick();
      checks++;
      if (grant_valid !== 3'b111 || clear !== 16'h0007 || grant_idx !== 12'h210) begin
         errors++;
         $display("FAIL parallel_grants got v=%b clr=%h idx=%h exp v=111 clr=0007 idx=210", grant_valid, clear, grant_idx);
      end
      quiesce();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         ready  = 16'($urandom);
         fu_sel = $urandom;
         age    = {$urandom, $urandom};
         head   = 4'($urandom_range(0, 15));
         for (int f = 0; f < 3; f++) stall[f] = ($urandom_range(0, 7) == 0);
         flush  = ($urandom_range(0, 15) == 0);
         rst    = ($urandom_range(0, 63) == 0);
         tick();
         checks++;
         if (grant_valid !== exp_valid) begin errors++; $display("FAIL rand_valid cyc %0d got %b exp %b", c, grant_valid, exp_valid); end
         checks++;
         if (grant_idx !== exp_idx) begin errors++; $display("FAIL rand_idx cyc %0d got %h exp %h", c, grant_idx, exp_idx); end
         checks++;
         if (clear !== exp_clear) begin errors++; $display("FAIL rand_clear cyc %0d got %h exp %h", c, clear, exp_clear); end
         checks++;
         if (fu_busy !== exp_busy) begin errors++; $display("FAIL rand_busy cyc %0d got %b exp %b", c, fu_busy, exp_busy); end
      end
      rst = 1'b0;
      quiesce();
   endtask

   initial begin
      for (int f = 0; f < 3; f++) m_cnt[f] = 0;
      test_reset();
      test_oldest_first();
      test_wrap();
      test_mem_occupancy();
      test_stall();
      test_flush_parallel();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
